// File: rtl/desc_credit_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : desc_credit_gen                                              |
// | Description : Accumulates per-queue consumed descriptors and returns them  |
// |               to the DMA as batched (qid, count) credit messages, using    |
// |               threshold/flush/timeout eligibility and round-robin pick.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module desc_credit_gen #(
  parameter int QID_WIDTH        = 3,
  parameter int DESC_AVAIL_WIDTH = 8,
  parameter int THRESH           = 16,
  parameter int TIMEOUT          = 512,
  parameter int TIMEOUT_WIDTH    = 10
) (
  input  logic                        user_clk,
  input  logic                        user_reset_n,
  input  logic                        desc_used,
  input  logic [QID_WIDTH-1:0]        desc_used_qid,
  input  logic                        q_flush,
  input  logic [QID_WIDTH-1:0]        q_flush_qid,
  input  logic                        q_clr,
  input  logic [QID_WIDTH-1:0]        q_clr_qid,
  output logic                        cred_vld,
  input  logic                        cred_rdy,
  output logic [QID_WIDTH-1:0]        cred_qid,
  output logic [DESC_AVAIL_WIDTH-1:0] cred_val,
  output logic                        pending,
  output logic                        overflow_err
);

  localparam int                          c_num_q      = 2**QID_WIDTH;
  localparam logic [DESC_AVAIL_WIDTH-1:0] c_thresh     = DESC_AVAIL_WIDTH'(THRESH);
  localparam logic [DESC_AVAIL_WIDTH-1:0] c_acc_max    = '1;
  localparam logic [TIMEOUT_WIDTH-1:0]    c_timer_last = TIMEOUT_WIDTH'(TIMEOUT - 1);
  localparam logic [QID_WIDTH-1:0]        c_rr_init    = '1;

  logic [DESC_AVAIL_WIDTH-1:0] r_acc [c_num_q];
  logic [c_num_q-1:0]          r_flush_req;
  logic [QID_WIDTH-1:0]        r_rr_ptr;
  logic [TIMEOUT_WIDTH-1:0]    r_timer;

  logic [c_num_q-1:0]          w_elig;
  logic                        w_found;
  logic [QID_WIDTH-1:0]        w_sel;
  logic                        w_load;
  logic                        w_timeout;
  logic [DESC_AVAIL_WIDTH-1:0] w_acc_nxt [c_num_q];
  logic [c_num_q-1:0]          w_flush_nxt;
  logic                        w_ovf;
  logic                        w_any_nz;

  // Per-queue eligibility; a same-cycle clear vetoes the queue.
  always_comb begin
    for (int q = 0; q < c_num_q; q++) begin
      w_elig[q] = (r_acc[q] != '0) &&
                  ((r_acc[q] >= c_thresh) || r_flush_req[q]) &&
                  !(q_clr && (q_clr_qid == QID_WIDTH'(q)));
    end
  end

  // Round-robin pick: first eligible queue after the last one served.
  always_comb begin
    logic [QID_WIDTH-1:0] idx;
    w_found = 1'b0;
    w_sel   = r_rr_ptr;
    idx     = r_rr_ptr;
    for (int i = 1; i <= c_num_q; i++) begin
      idx = r_rr_ptr + QID_WIDTH'(i);
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_sel   = idx;
      end
    end
  end

  assign w_load    = (!cred_vld || cred_rdy) && w_found;
  assign w_timeout = pending && (r_timer == c_timer_last);

  // Next accumulator / flush-request state; clear wins, then load, then increment.
  always_comb begin
    logic inc;
    logic clr;
    logic fl;
    logic ld;
    logic nz;
    w_ovf    = 1'b0;
    w_any_nz = 1'b0;
    inc      = 1'b0;
    clr      = 1'b0;
    fl       = 1'b0;
    ld       = 1'b0;
    nz       = 1'b0;
    for (int q = 0; q < c_num_q; q++) begin
      inc            = desc_used && (desc_used_qid == QID_WIDTH'(q));
      clr            = q_clr && (q_clr_qid == QID_WIDTH'(q));
      fl             = q_flush && (q_flush_qid == QID_WIDTH'(q));
      ld             = w_load && (w_sel == QID_WIDTH'(q));
      nz             = (r_acc[q] != '0);
      w_any_nz       = w_any_nz | nz;
      w_acc_nxt[q]   = r_acc[q];
      w_flush_nxt[q] = r_flush_req[q];
      if (clr) begin
        w_acc_nxt[q]   = '0;
        w_flush_nxt[q] = 1'b0;
      end else if (ld) begin
        // The count leaves in the message; only a same-cycle descriptor stays.
        w_acc_nxt[q]   = {{(DESC_AVAIL_WIDTH-1){1'b0}}, inc};
        w_flush_nxt[q] = fl && inc;
      end else begin
        if (inc) begin
          if (r_acc[q] == c_acc_max) begin
            w_ovf = 1'b1;
          end else begin
            w_acc_nxt[q] = r_acc[q] + DESC_AVAIL_WIDTH'(1);
          end
        end
        if ((fl && (nz || inc)) || (w_timeout && nz)) begin
          w_flush_nxt[q] = 1'b1;
        end
      end
    end
  end

  // Accumulator and flush-request registers.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      for (int q = 0; q < c_num_q; q++) begin
        r_acc[q] <= '0;
      end
      r_flush_req <= '0;
    end else begin
      for (int q = 0; q < c_num_q; q++) begin
        r_acc[q] <= w_acc_nxt[q];
      end
      r_flush_req <= w_flush_nxt;
    end
  end

  // Output message register and round-robin pointer.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      cred_vld <= 1'b0;
      cred_qid <= '0;
      cred_val <= '0;
      r_rr_ptr <= c_rr_init;
    end else if (w_load) begin
      cred_vld <= 1'b1;
      cred_qid <= w_sel;
      cred_val <= r_acc[w_sel];
      r_rr_ptr <= w_sel;
    end else if (cred_rdy) begin
      cred_vld <= 1'b0;
    end
  end

  // Pending flag, idle timer (not restarted by loads) and sticky overflow.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      pending      <= 1'b0;
      r_timer      <= '0;
      overflow_err <= 1'b0;
    end else begin
      pending      <= w_any_nz;
      overflow_err <= overflow_err | w_ovf;
      if (!pending || w_timeout) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TIMEOUT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire
